// File: rtl/mb_decimate_scheduler_if.sv
// Handshake bundle between the macroblock scheduler and its three peers:
// the source buffer (src_*), the decision datapath (dec_*) and the
// downstream result consumer (out_*). The scheduler takes the master view.
interface mb_decimate_scheduler_if;
  logic       src_valid;
  logic       src_ready;
  logic       dec_start;
  logic [9:0] dec_x;
  logic [9:0] dec_y;
  logic       dec_done;
  logic [7:0] dec_skipped;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_x;
  logic [9:0] out_y;
  logic       out_last;

  modport master (
    input  src_valid, dec_done, dec_skipped, out_ready,
    output src_ready, dec_start, dec_x, dec_y, out_valid, out_x, out_y, out_last
  );

  modport slave (
    output src_valid, dec_done, dec_skipped, out_ready,
    input  src_ready, dec_start, dec_x, dec_y, out_valid, out_x, out_y, out_last
  );
endinterface

// File: rtl/mb_decimate_scheduler.sv
// Raster-order macroblock scheduler: pulls one macroblock from the source
// buffer, kicks the decision datapath, waits for completion under a
// watchdog, then presents the result slot downstream. Counts skipped
// macroblocks and signals frame completion.
module mb_decimate_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 4095,
  parameter int unsigned SKIP_CNT_W     = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [9:0]            cfg_mb_w,
  input  logic [9:0]            cfg_mb_h,
  mb_decimate_scheduler_if.master bus,
  output logic                  busy,
  output logic                  frame_done,
  output logic [SKIP_CNT_W-1:0] skip_count,
  output logic                  timeout_err
);

  localparam int unsigned     WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WAIT_SRC = 3'd1,
    S_START    = 3'd2,
    S_RUN      = 3'd3,
    S_EMIT     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [9:0]            x_q, x_d;
  logic [9:0]            y_q, y_d;
  logic [9:0]            w_q, w_d;
  logic [9:0]            h_q, h_d;
  logic [WD_W-1:0]       wd_q, wd_d;
  logic [SKIP_CNT_W-1:0] skip_q, skip_d;
  logic                  tmo_q, tmo_d;
  logic                  fdone_q, fdone_d;
  logic                  last_mb;

  // Final macroblock is judged against the configuration latched at frame
  // start, so cfg inputs can move freely mid-frame.
  assign last_mb = (x_q == w_q - 10'd1) && (y_q == h_q - 10'd1);

  // All handshake outputs are decoded straight from the state register.
  assign bus.src_ready = (state_q == S_WAIT_SRC);
  assign bus.dec_start = (state_q == S_START);
  assign bus.dec_x     = x_q;
  assign bus.dec_y     = y_q;
  assign bus.out_valid = (state_q == S_EMIT);
  assign bus.out_x     = x_q;
  assign bus.out_y     = y_q;
  assign bus.out_last  = (state_q == S_EMIT) && last_mb;
  assign busy          = (state_q != S_IDLE);
  assign frame_done    = fdone_q;
  assign skip_count    = skip_q;
  assign timeout_err   = tmo_q;

  // Next-state, coordinate stepping, watchdog and counters.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    wd_d    = wd_q;
    skip_d  = skip_q;
    tmo_d   = tmo_q;
    fdone_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          if (cfg_mb_w != 10'd0 && cfg_mb_h != 10'd0) begin
            w_d     = cfg_mb_w;
            h_d     = cfg_mb_h;
            x_d     = 10'd0;
            y_d     = 10'd0;
            skip_d  = '0;
            tmo_d   = 1'b0;
            state_d = S_WAIT_SRC;
          end else begin
            // Empty frame: nothing to schedule, just report completion.
            fdone_d = 1'b1;
          end
        end
      end

      S_WAIT_SRC: begin
        if (bus.src_valid) begin
          state_d = S_START;
        end
      end

      S_START: begin
        wd_d    = '0;
        state_d = S_RUN;
      end

      S_RUN: begin
        // Completion takes priority over a watchdog expiry on the same cycle.
        if (bus.dec_done) begin
          if ((bus.dec_skipped != 8'd0) && !(&skip_q)) begin
            skip_d = skip_q + 1'b1;
          end
          state_d = S_EMIT;
        end else begin
          wd_d = wd_q + 1'b1;
          if (wd_d == WD_LIMIT) begin
            tmo_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_EMIT: begin
        if (bus.out_ready) begin
          if (last_mb) begin
            fdone_d = 1'b1;
            state_d = S_DONE;
          end else begin
            if (x_q == w_q - 10'd1) begin
              x_d = 10'd0;
              y_d = y_q + 10'd1;
            end else begin
              x_d = x_q + 10'd1;
            end
            state_d = S_WAIT_SRC;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= 10'd0;
      y_q     <= 10'd0;
      w_q     <= 10'd0;
      h_q     <= 10'd0;
      wd_q    <= '0;
      skip_q  <= '0;
      tmo_q   <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      wd_q    <= wd_d;
      skip_q  <= skip_d;
      tmo_q   <= tmo_d;
      fdone_q <= fdone_d;
    end
  end

endmodule
